reg_writeback_queue: RTL and testbench
======================================

Name: reg_writeback_queue

Overview:
- Initiator side of the register-table write port.
- Accepts completed results from the ALU path and the load (memory) path over valid/ready.
- Buffers results in a small in-order queue and drains them one per cycle onto the register table's single write port (register_d / data_register_d_in / write_register_d).
- Exposes a bypass lookup so the operand-read stage sees values still pending in the queue.

Parameters:
- DATA_W, 32, width of a register value.
- ADDR_W, 5, width of a register index.
- NUM_REGS, 26, number of implemented registers; valid indices are 0..NUM_REGS-1.
- DEPTH, 4, queue entries; power of two, >=2.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid & alu_ready.
- alu_reg  in  ADDR_W  ALU destination index.
- alu_data  in  DATA_W  ALU result.
- mem_valid  in  1  load result offered.
- mem_ready  out  1  load result accepted when mem_valid & mem_ready.
- mem_reg  in  ADDR_W  load destination index.
- mem_data  in  DATA_W  load result.
- register_d  out  ADDR_W  write index to register table.
- data_register_d_in  out  DATA_W  write data to register table.
- write_register_d  out  1  write strobe to register table.
- lookup_reg_a, lookup_reg_b  in  ADDR_W  operand indices being read.
- lookup_hit_a, lookup_hit_b  out  1  a pending entry matches.
- lookup_data_a, lookup_data_b  out  DATA_W  youngest matching pending value.
- pending_count  out  $clog2(DEPTH)+1  entries held.
- idle  out  1  queue empty.
- drop_err  out  1  one-cycle pulse: an accepted result had an index >= NUM_REGS.

Behaviour:
- Reset: queue emptied, pending_count=0, idle=1, write_register_d=0, register_d=0, data_register_d_in=0, drop_err=0. Reset mid-operation discards all pending entries; no write is issued in the reset cycle or after it.
- Drain: write_register_d = !empty, combinational from the queue head. register_d and data_register_d_in show the head entry, and are 0 when empty. The head pops every non-empty cycle; the register table commits it on the same edge.
- Latency: a result accepted at edge N is written at edge N+1 if the queue was empty.
- Free slots this cycle: free = DEPTH - count + (count != 0), which credits the simultaneous pop.
- Ready: mem_ready = (free >= 1). alu_ready = (free >= 2) | (free >= 1 & !mem_valid). Load has priority.
- Both accepted in one cycle: the mem entry is enqueued before the alu entry, so the mem entry is older.
- Full with no pop cannot occur, because the head always pops. At count == DEPTH, free = 1: only one result is accepted, mem preferred.
- Out-of-range index (>= NUM_REGS): the result is handshaken (ready as normal) but not enqueued, and drop_err pulses (registered) on the next cycle.
- Lookup: compares against all valid entries, including the head being written this cycle. The youngest match wins. Same-cycle incoming results are not visible.
- Lookup misses give hit=0 and data=0.
- Index 0 is an ordinary register: no hard-wired zero.
- Counter arithmetic: pending_count next = count + pushes(0..2) - pop(0..1). Pointers wrap modulo DEPTH.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: lookup logic as above.
- Undefined: lookup_hit_* = 0 and lookup_data_* = 0 constant; the ports remain and no comparators are built.

Decomposition:
- Package reg_wb_pkg holds DATA_W, ADDR_W, NUM_REGS constants and the typedef wb_entry_t {reg index, data}.
- Sub-module reg_wb_fifo: DEPTH-entry circular buffer with dual push (ordered) / single pop, count, and an entry-array view for the lookup.
- The top level holds arbitration, range check, drop_err and the bypass.

Test Plan:
- Reset, then alu_valid, alu_reg=3, alu_data=0x55 for one cycle -> next cycle write_register_d=1, register_d=3, data=0x55; the following cycle idle=1.
- Same cycle: mem (reg 2, 0xAA) and alu (reg 2, 0xBB) with an empty queue -> both ready. Writes follow in order: reg2=0xAA, then reg2=0xBB. lookup_reg_a=2 between them -> hit=1, data=0xBB.
- Hold both sources valid continuously with DEPTH=4 -> ready pattern matches the free-slot rule. mem is never stalled while alu is accepted. No entry is lost or reordered; compare against a scoreboard over 50 cycles.
- alu_reg=26, data=0x1 -> alu_ready=1, no write, drop_err=1 exactly one cycle later.
- Fill 3 entries, assert reset for one cycle -> no write_register_d after reset, pending_count=0, and the lookup of any enqueued register gives hit=0.
- Build without WB_BYPASS_EN, repeating the scenario-2 stimulus -> lookup_hit_a=0, lookup_data_a=0. Write sequence is unchanged.

Source files
------------

// File: rtl/reg_wb_pkg.sv
// Shared widths and the queue entry type for the register-table writeback path.
package reg_wb_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 26;

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/reg_wb_fifo.sv
// Circular buffer with ordered dual push, single pop, and an oldest-first entry view.
module reg_wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_a_en,
  input  wb_entry_t             push_a,
  input  logic                  push_b_en,
  input  wb_entry_t             push_b,
  input  logic                  pop,
  output wb_entry_t             head,
  output logic                  empty,
  output logic [CW-1:0]         count,
  output wb_entry_t [DEPTH-1:0] ord,
  output logic [DEPTH-1:0]      ord_vld
);
  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pop_int;

  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = mem_q[rd_q];
  assign pop_int = pop & ~empty;

  // push_b only ever accompanies push_a, so it always lands one slot behind it
  always_comb begin
    mem_d = mem_q;
    if (push_a_en) mem_d[wr_q] = push_a;
    if (push_b_en) mem_d[wr_q + PW'(1)] = push_b;
    wr_d  = wr_q + PW'(push_a_en) + PW'(push_b_en);
    rd_d  = rd_q + PW'(pop_int);
    cnt_d = cnt_q + CW'(push_a_en) + CW'(push_b_en) - CW'(pop_int);
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ord[k]     = mem_q[rd_q + PW'(k)];
      ord_vld[k] = (CW'(k) < cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
    mem_q <= mem_d;
  end
endmodule

// File: rtl/reg_writeback_queue.sv
// Writeback queue feeding the register table; widths come from reg_wb_pkg.
// Optional macro WB_BYPASS_EN builds the pending-value lookup comparators.
module reg_writeback_queue
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] register_d,
  output logic [DATA_W-1:0] data_register_d_in,
  output logic              write_register_d,
  input  logic [ADDR_W-1:0] lookup_reg_a,
  input  logic [ADDR_W-1:0] lookup_reg_b,
  output logic              lookup_hit_a,
  output logic              lookup_hit_b,
  output logic [DATA_W-1:0] lookup_data_a,
  output logic [DATA_W-1:0] lookup_data_b,
  output logic [CW-1:0]     pending_count,
  output logic              idle,
  output logic              drop_err
);
  wb_entry_t             head, push_a, push_b;
  wb_entry_t [DEPTH-1:0] ord;
  logic [DEPTH-1:0]      ord_vld;
  logic                  empty, push_a_en, push_b_en;
  logic [CW-1:0]         count;
  logic [CW:0]           free;
  logic                  mem_acc, alu_acc, mem_oor, alu_oor, mem_enq, alu_enq;
  logic                  drop_err_q, drop_err_d;

  // The head pops every non-empty cycle, so its slot is free for this cycle's push
  assign free      = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(count != '0);
  assign mem_ready = ~reset & (free >= (CW+1)'(1));
  assign alu_ready = ~reset & ((free >= (CW+1)'(2)) | ((free >= (CW+1)'(1)) & ~mem_valid));

  assign mem_acc = mem_valid & mem_ready;
  assign alu_acc = alu_valid & alu_ready;
  assign mem_oor = (int'(mem_reg) >= NUM_REGS);
  assign alu_oor = (int'(alu_reg) >= NUM_REGS);
  assign mem_enq = mem_acc & ~mem_oor;
  assign alu_enq = alu_acc & ~alu_oor;

  // Compress the accepted results so the load is always the older entry
  assign push_a_en = mem_enq | alu_enq;
  assign push_b_en = mem_enq & alu_enq;
  assign push_a    = mem_enq ? wb_entry_t'{idx: mem_reg, data: mem_data}
                             : wb_entry_t'{idx: alu_reg, data: alu_data};
  assign push_b    = wb_entry_t'{idx: alu_reg, data: alu_data};

  reg_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_a_en (push_a_en),
    .push_a    (push_a),
    .push_b_en (push_b_en),
    .push_b    (push_b),
    .pop       (~empty),
    .head      (head),
    .empty     (empty),
    .count     (count),
    .ord       (ord),
    .ord_vld   (ord_vld)
  );

  assign write_register_d   = ~empty & ~reset;
  assign register_d         = write_register_d ? head.idx  : '0;
  assign data_register_d_in = write_register_d ? head.data : '0;
  assign pending_count      = count;
  assign idle               = empty;

  assign drop_err_d = (mem_acc & mem_oor) | (alu_acc & alu_oor);
  always_ff @(posedge clk) begin
    if (reset) drop_err_q <= 1'b0;
    else       drop_err_q <= drop_err_d;
  end
  assign drop_err = drop_err_q;

`ifdef WB_BYPASS_EN
  // Scan oldest to youngest so the last match left standing is the youngest
  always_comb begin
    lookup_hit_a  = 1'b0;
    lookup_hit_b  = 1'b0;
    lookup_data_a = '0;
    lookup_data_b = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ord_vld[k] && ord[k].idx == lookup_reg_a) begin
        lookup_hit_a  = 1'b1;
        lookup_data_a = ord[k].data;
      end
      if (ord_vld[k] && ord[k].idx == lookup_reg_b) begin
        lookup_hit_b  = 1'b1;
        lookup_data_b = ord[k].data;
      end
    end
  end
`else
  logic unused_lookup;
  assign unused_lookup = ^{ord, ord_vld, lookup_reg_a, lookup_reg_b};
  assign lookup_hit_a  = 1'b0;
  assign lookup_hit_b  = 1'b0;
  assign lookup_data_a = '0;
  assign lookup_data_b = '0;
`endif
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed and randomized checks of reg_writeback_queue against a queue-based model.
module tb_reg_writeback_queue;
  localparam int DEPTH = 4;
  localparam int NREGS = 26;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [4:0]  alu_reg, mem_reg, register_d, lookup_reg_a, lookup_reg_b;
  logic [31:0] alu_data, mem_data, data_register_d_in, lookup_data_a, lookup_data_b;
  logic        write_register_d, lookup_hit_a, lookup_hit_b, idle, drop_err;
  logic [2:0]  pending_count;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  bit   exp_drop;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  reg_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .register_d(register_d), .data_register_d_in(data_register_d_in),
    .write_register_d(write_register_d),
    .lookup_reg_a(lookup_reg_a), .lookup_reg_b(lookup_reg_b),
    .lookup_hit_a(lookup_hit_a), .lookup_hit_b(lookup_hit_b),
    .lookup_data_a(lookup_data_a), .lookup_data_b(lookup_data_b),
    .pending_count(pending_count), .idle(idle), .drop_err(drop_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Youngest pending value for a register, or a miss
  task automatic model_lookup(input logic [4:0] r, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
`ifdef WB_BYPASS_EN
    foreach (q[i]) if (q[i].r == r) begin
      hit = 1'b1;
      d   = q[i].d;
    end
`endif
  endtask

  // One clock: drive at the falling edge, check, then advance the model on the rising edge
  task automatic cyc(input bit rst, input bit mv, input logic [4:0] mr, input logic [31:0] md,
                     input bit av, input logic [4:0] ar, input logic [31:0] ad,
                     input logic [4:0] la, input logic [4:0] lb);
    int          n, free;
    bit          emr, ear, ew, d;
    logic        eh;
    logic [31:0] ed;
    reset = rst; mem_valid = mv; mem_reg = mr; mem_data = md;
    alu_valid = av; alu_reg = ar; alu_data = ad; lookup_reg_a = la; lookup_reg_b = lb;
    #1;
    n    = q.size();
    free = DEPTH - n + ((n != 0) ? 1 : 0);
    emr  = !rst && free >= 1;
    ear  = !rst && (free >= 2 || (free >= 1 && !mv));
    ew   = !rst && n > 0;
    chk("write_strobe", 32'(write_register_d), 32'(ew));
    chk("write_reg", 32'(register_d), ew ? 32'(q[0].r) : 32'd0);
    chk("write_data", data_register_d_in, ew ? q[0].d : 32'd0);
    if (!rst) begin
      chk("mem_ready", 32'(mem_ready), 32'(emr));
      chk("alu_ready", 32'(alu_ready), 32'(ear));
      chk("pending_count", 32'(pending_count), 32'(n));
      chk("idle", 32'(idle), 32'(n == 0));
      chk("drop_err", 32'(drop_err), 32'(exp_drop));
      model_lookup(la, eh, ed);
      chk("hit_a", 32'(lookup_hit_a), 32'(eh));
      chk("data_a", lookup_data_a, ed);
      model_lookup(lb, eh, ed);
      chk("hit_b", 32'(lookup_hit_b), 32'(eh));
      chk("data_b", lookup_data_b, ed);
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      exp_drop = 1'b0;
    end else begin
      d = 1'b0;
      if (n > 0) void'(q.pop_front());
      if (mv && emr) begin
        if (mr < NREGS) q.push_back('{r: mr, d: md});
        else d = 1'b1;
      end
      if (av && ear) begin
        if (ar < NREGS) q.push_back('{r: ar, d: ad});
        else d = 1'b1;
      end
      exp_drop = d;
    end
    @(negedge clk);
  endtask

  task automatic idle_cyc(input logic [4:0] la);
    cyc(0, 0, 0, 0, 0, 0, 0, la, 0);
  endtask

  function automatic logic [4:0] rnd_reg();
    if ($urandom_range(0, 7) == 0) return 5'($urandom_range(26, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    reset = 1'b1; mem_valid = 0; alu_valid = 0; mem_reg = 0; alu_reg = 0;
    mem_data = 0; alu_data = 0; lookup_reg_a = 0; lookup_reg_b = 0;
    exp_drop = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // single ALU result, written next cycle, then idle
    cyc(0, 0, 0, 0, 1, 5'd3, 32'h55, 3, 0);
    idle_cyc(3);
    idle_cyc(3);

    // simultaneous load and ALU to the same register; lookup sees the younger value
    cyc(0, 1, 5'd2, 32'hAA, 1, 5'd2, 32'hBB, 2, 0);
    idle_cyc(2);
    idle_cyc(2);
    idle_cyc(2);

    // both sources valid continuously: exercises the full-queue ready rule
    for (int i = 0; i < 50; i++)
      cyc(0, 1, 5'($urandom_range(0, 25)), $urandom, 1, 5'($urandom_range(0, 25)), $urandom,
          5'($urandom_range(0, 25)), 5'($urandom_range(0, 25)));
    repeat (5) idle_cyc(0);

    // out-of-range ALU index: handshaken, dropped, error pulse one cycle later
    cyc(0, 0, 0, 0, 1, 5'd26, 32'h1, 26, 0);
    idle_cyc(26);
    idle_cyc(26);

    // three entries pending, then reset discards them
    cyc(0, 1, 5'd7, 32'h700, 1, 5'd8, 32'h800, 7, 8);
    cyc(0, 1, 5'd9, 32'h900, 1, 5'd10, 32'hA00, 9, 10);
    cyc(1, 0, 0, 0, 0, 0, 0, 9, 10);
    cyc(0, 0, 0, 0, 0, 0, 0, 9, 10);
    idle_cyc(8);

    // randomized traffic with out-of-range indices and random lookups
    for (int i = 0; i < 300; i++)
      cyc(($urandom_range(0, 63) == 0), $urandom_range(0, 1), rnd_reg(), $urandom,
          $urandom_range(0, 1), rnd_reg(), $urandom,
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    repeat (5) idle_cyc(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
